// File: rtl/dict_load_ctrl.sv
// Dictionary load sequencer: streams a boot-ROM table into the dictionary as one unbroken
// write burst and gates encoder/decoder lookups until the table is valid. Optional: DICT_LOAD_CHECKSUM_EN.
module dict_load_ctrl #(
   parameter int unsigned KEY_WIDTH = 7,
   parameter int unsigned VAL_WIDTH = 13,
   parameter int unsigned ROM_BASE  = 0
) (
`ifdef DICT_LOAD_CHECKSUM_EN
   input  logic [VAL_WIDTH-1:0] load_csum_exp,
   output logic                 load_err,
`endif
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_start,
   output logic                 load_busy,
   output logic                 load_done,
   output logic                 rom_rd_en,
   output logic [15:0]          rom_addr,
   input  logic [VAL_WIDTH-1:0] rom_data,
   output logic                 dict_we,
   output logic [VAL_WIDTH-1:0] dict_wval,
   output logic [KEY_WIDTH-1:0] dict_key_lookup,
   output logic [VAL_WIDTH-1:0] dict_val_lookup,
   input  logic [VAL_WIDTH-1:0] dict_val_out,
   input  logic [KEY_WIDTH-1:0] dict_key_out,
   input  logic                 dict_hit,
   input  logic                 enc_req_valid,
   output logic                 enc_req_ready,
   input  logic [VAL_WIDTH-1:0] enc_req_val,
   output logic                 enc_resp_valid,
   output logic                 enc_resp_hit,
   output logic [KEY_WIDTH-1:0] enc_resp_key,
   input  logic                 dec_req_valid,
   output logic                 dec_req_ready,
   input  logic [KEY_WIDTH-1:0] dec_req_key,
   output logic                 dec_resp_valid,
   output logic [VAL_WIDTH-1:0] dec_resp_val
);

   localparam int unsigned CW = KEY_WIDTH + 1;
   localparam int unsigned N  = 1 << KEY_WIDTH;
   localparam int unsigned AW = 16;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READY} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
   logic            rd_en_d1_q;
   logic            ready_q, ready_d;
   logic            rom_rd_en_d;
   logic [AW-1:0]   rom_addr_d;
   logic            busy_d, done_d;
   logic            start_acc, finish;
   logic            enc_fire, dec_fire;
   logic            err_d;
`ifdef DICT_LOAD_CHECKSUM_EN
   logic [VAL_WIDTH-1:0] acc_q, acc_d;
`endif

   assign dict_val_lookup = enc_req_val;
   assign dict_key_lookup = dec_req_key;
   assign enc_req_ready   = ready_q;
   assign dec_req_ready   = ready_q;
   assign enc_fire        = enc_req_valid && ready_q;
   assign dec_fire        = dec_req_valid && ready_q;

   // Next-state, counters and registered-output next values
   always_comb begin
      state_d     = state_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      rom_rd_en_d = 1'b0;
      rom_addr_d  = rom_addr;
      start_acc   = load_start && (state_q == IDLE || state_q == READY);
      finish      = dict_we && (wr_cnt_q == CW'(N - 1));
      err_d       = 1'b0;
      if (dict_we) wr_cnt_d = wr_cnt_q + CW'(1);
      case (state_q)
         IDLE, READY: begin
            if (load_start) begin
               state_d  = LOAD;
               rd_cnt_d = '0;
               wr_cnt_d = '0;
            end
         end
         LOAD: begin
            rom_rd_en_d = 1'b1;
            rom_addr_d  = AW'(ROM_BASE) + AW'(rd_cnt_q);
            rd_cnt_d    = rd_cnt_q + CW'(1);
            if (rd_cnt_q == CW'(N - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (finish) state_d = READY;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_q == LOAD || state_q == DRAIN) && !finish;
      done_d = (state_q == READY) || finish;
`ifdef DICT_LOAD_CHECKSUM_EN
      acc_d = acc_q;
      err_d = load_err;
      if (start_acc) begin
         acc_d = '0;
         err_d = 1'b0;
      end else begin
         if (dict_we) acc_d = acc_q ^ dict_wval;
         // final word is still in dict_wval when the burst completes
         if (finish) err_d = ((acc_q ^ dict_wval) != load_csum_exp);
      end
`endif
      ready_d = (state_d == READY) && !err_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         rd_cnt_q       <= '0;
         wr_cnt_q       <= '0;
         rd_en_d1_q     <= 1'b0;
         ready_q        <= 1'b0;
         rom_rd_en      <= 1'b0;
         rom_addr       <= '0;
         dict_we        <= 1'b0;
         dict_wval      <= '0;
         load_busy      <= 1'b0;
         load_done      <= 1'b0;
         enc_resp_valid <= 1'b0;
         enc_resp_hit   <= 1'b0;
         enc_resp_key   <= '0;
         dec_resp_valid <= 1'b0;
         dec_resp_val   <= '0;
`ifdef DICT_LOAD_CHECKSUM_EN
         acc_q          <= '0;
         load_err       <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         rd_cnt_q       <= rd_cnt_d;
         wr_cnt_q       <= wr_cnt_d;
         rom_rd_en      <= rom_rd_en_d;
         rom_addr       <= rom_addr_d;
         rd_en_d1_q     <= rom_rd_en;
         dict_we        <= rd_en_d1_q;
         dict_wval      <= rom_data;
         ready_q        <= ready_d;
         load_busy      <= busy_d;
         load_done      <= done_d;
         enc_resp_valid <= enc_fire;
         dec_resp_valid <= dec_fire;
         if (enc_fire) begin
            enc_resp_hit <= dict_hit;
            enc_resp_key <= dict_key_out;
         end
         if (dec_fire) dec_resp_val <= dict_val_out;
`ifdef DICT_LOAD_CHECKSUM_EN
         acc_q          <= acc_d;
         load_err       <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_dict_load_ctrl.sv
// Bench for dict_load_ctrl with ROM and dictionary environment models.
module tb_dict_load_ctrl;
   localparam int unsigned KW = 7;
   localparam int unsigned VW = 13;
   localparam int unsigned N  = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_start;
   logic          load_busy, load_done;
   logic          rom_rd_en;
   logic [15:0]   rom_addr;
   logic [VW-1:0] rom_data = '0;
   logic          dict_we;
   logic [VW-1:0] dict_wval;
   logic [KW-1:0] dict_key_lookup;
   logic [VW-1:0] dict_val_lookup;
   logic [VW-1:0] dict_val_out;
   logic [KW-1:0] dict_key_out;
   logic          dict_hit;
   logic          enc_req_valid, enc_req_ready;
   logic [VW-1:0] enc_req_val;
   logic          enc_resp_valid, enc_resp_hit;
   logic [KW-1:0] enc_resp_key;
   logic          dec_req_valid, dec_req_ready;
   logic [KW-1:0] dec_req_key;
   logic          dec_resp_valid;
   logic [VW-1:0] dec_resp_val;
`ifdef DICT_LOAD_CHECKSUM_EN
   logic [VW-1:0] load_csum_exp;
   logic          load_err;
`endif

   int total = 0;
   int bad   = 0;
   bit loaded = 1'b0;

   logic [VW-1:0] rom      [N];
   logic [VW-1:0] dict_exp [N];
   logic [VW-1:0] dmem     [N];
   logic [KW-1:0] didx = '0;

   dict_load_ctrl dut (
`ifdef DICT_LOAD_CHECKSUM_EN
      .load_csum_exp(load_csum_exp), .load_err(load_err),
`endif
      .clk(clk), .reset(reset), .load_start(load_start), .load_busy(load_busy),
      .load_done(load_done), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .dict_we(dict_we), .dict_wval(dict_wval), .dict_key_lookup(dict_key_lookup),
      .dict_val_lookup(dict_val_lookup), .dict_val_out(dict_val_out), .dict_key_out(dict_key_out),
      .dict_hit(dict_hit), .enc_req_valid(enc_req_valid), .enc_req_ready(enc_req_ready),
      .enc_req_val(enc_req_val), .enc_resp_valid(enc_resp_valid), .enc_resp_hit(enc_resp_hit),
      .enc_resp_key(enc_resp_key), .dec_req_valid(dec_req_valid), .dec_req_ready(dec_req_ready),
      .dec_req_key(dec_req_key), .dec_resp_valid(dec_resp_valid), .dec_resp_val(dec_resp_val)
   );

   always #5 clk = ~clk;

   // ROM: data one cycle after the read strobe
   always @(posedge clk) rom_data <= rom_rd_en ? rom[rom_addr[KW-1:0]] : '0;

   // Dictionary: write index rewinds whenever write enable is low
   always @(posedge clk) begin
      if (dict_we) begin
         dmem[didx] <= dict_wval;
         didx       <= didx + KW'(1);
      end else begin
         didx <= '0;
      end
   end

   always_comb begin
      dict_val_out = dmem[dict_key_lookup];
      dict_hit     = 1'b0;
      dict_key_out = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (dmem[i] == dict_val_lookup) begin
            dict_hit     = 1'b1;
            dict_key_out = KW'(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rom(input int mode);
      logic [VW-1:0] base;
      base = VW'($urandom);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       rom[i] = VW'(i + 100);
            1:       rom[i] = VW'(i);
            default: rom[i] = base + VW'(37 * i);
         endcase
      end
   endtask

   task automatic find(input logic [VW-1:0] v, output bit hit, output logic [KW-1:0] key);
      hit = 1'b0;
      key = '0;
      for (int i = 0; i < N; i++) begin
         if (!hit && dict_exp[i] == v) begin
            hit = 1'b1;
            key = KW'(i);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; load_start = 1'b0;
      enc_req_valid = 1'b0; enc_req_val = '0; dec_req_valid = 1'b0; dec_req_key = '0;
`ifdef DICT_LOAD_CHECKSUM_EN
      load_csum_exp = '0;
`endif
      #23;
      total++;
      if ({load_busy, load_done, rom_rd_en, dict_we, enc_req_ready, dec_req_ready,
           enc_resp_valid, dec_resp_valid} !== 8'h00) begin
         bad++;
         $display("FAIL reset_ctl got=%b exp=00000000", {load_busy, load_done, rom_rd_en, dict_we,
                  enc_req_ready, dec_req_ready, enc_resp_valid, dec_resp_valid});
      end
      total++;
      if (rom_addr !== 16'h0 || dict_wval !== '0) begin
         bad++;
         $display("FAIL reset_data got addr=%0h wval=%0h exp=0", rom_addr, dict_wval);
      end
      reset = 1'b0;
      loaded = 1'b0;
      tick();
   endtask

   task automatic test_idle_lookup();
      enc_req_valid = 1'b1; enc_req_val = VW'(105);
      dec_req_valid = 1'b1; dec_req_key = KW'(3);
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if ({enc_req_ready, dec_req_ready, enc_resp_valid, dec_resp_valid} !== 4'b0) begin
            bad++;
            $display("FAIL idle_gate k=%0d got=%b exp=0000", k,
                     {enc_req_ready, dec_req_ready, enc_resp_valid, dec_resp_valid});
         end
      end
      enc_req_valid = 1'b0; dec_req_valid = 1'b0;
   endtask

   // One full load; from_ready adds a same-cycle request, hold_req keeps a request pending throughout
   task automatic run_load(input bit from_ready, input bit hold_req, input bit csum_bad);
      logic [VW-1:0] x;
      bit exp_ready;
      x = '0;
      for (int i = 0; i < N; i++) x ^= rom[i];
`ifdef DICT_LOAD_CHECKSUM_EN
      load_csum_exp = csum_bad ? ~x : x;
`endif
      load_start = 1'b1;
      if (from_ready) begin
         enc_req_valid = 1'b1; enc_req_val = dict_exp[9];
      end
      if (hold_req) begin
         enc_req_valid = 1'b1; enc_req_val = VW'(105);
      end
      @(posedge clk);
      #1;
      load_start = 1'b0;
      if (!hold_req) enc_req_valid = 1'b0;
      for (int k = 0; k < N + 6; k++) begin
         total++;
         if (rom_rd_en !== (k >= 1 && k <= N)) begin
            bad++; $display("FAIL rd_en k=%0d got=%b", k, rom_rd_en);
         end
         if (k >= 1 && k <= N) begin
            total++;
            if (rom_addr !== 16'(k - 1)) begin
               bad++; $display("FAIL rom_addr k=%0d got=%0d exp=%0d", k, rom_addr, k - 1);
            end
         end
         total++;
         if (dict_we !== (k >= 3 && k <= N + 2)) begin
            bad++; $display("FAIL dict_we k=%0d got=%b", k, dict_we);
         end
         if (k >= 3 && k <= N + 2) begin
            total++;
            if (dict_wval !== rom[k-3]) begin
               bad++; $display("FAIL wval k=%0d got=%0d exp=%0d", k, dict_wval, rom[k-3]);
            end
         end
         total++;
         if (load_busy !== (k >= 1 && k <= N + 2)) begin
            bad++; $display("FAIL busy k=%0d got=%b", k, load_busy);
         end
         total++;
         if (load_done !== ((k == 0) ? loaded : (k >= N + 3))) begin
            bad++; $display("FAIL done k=%0d got=%b", k, load_done);
         end
         exp_ready = (k >= N + 3) && !csum_bad;
         total++;
         if (enc_req_ready !== exp_ready || dec_req_ready !== exp_ready) begin
            bad++; $display("FAIL ready k=%0d got=%b%b exp=%b", k, enc_req_ready, dec_req_ready, exp_ready);
         end
`ifdef DICT_LOAD_CHECKSUM_EN
         total++;
         if (load_err !== (k >= N + 3 && csum_bad)) begin
            bad++; $display("FAIL load_err k=%0d got=%b", k, load_err);
         end
`endif
         total++;
         if (k == 0 && from_ready) begin
            if (enc_resp_valid !== 1'b1 || enc_resp_hit !== 1'b1 || enc_resp_key !== KW'(9)) begin
               bad++; $display("FAIL start_req_resp got v=%b h=%b key=%0d exp v=1 h=1 key=9",
                               enc_resp_valid, enc_resp_hit, enc_resp_key);
            end
         end else if (enc_resp_valid !== (hold_req && k >= N + 4 && !csum_bad) || dec_resp_valid !== 1'b0) begin
            bad++; $display("FAIL load_resp k=%0d got enc=%b dec=%b", k, enc_resp_valid, dec_resp_valid);
         end
         tick();
      end
      enc_req_valid = 1'b0;
      for (int i = 0; i < N; i++) dict_exp[i] = rom[i];
      loaded = 1'b1;
      tick();
   endtask

   task automatic test_lookup(input int n, input bit directed);
      bit pe_v, pd_v, h;
      logic [VW-1:0] pe_val;
      logic [KW-1:0] pd_key, kk;
      pe_v = 1'b0; pd_v = 1'b0; pe_val = '0; pd_key = '0;
      for (int it = 0; it <= n; it++) begin
         total++;
         if (enc_resp_valid !== pe_v) begin
            bad++; $display("FAIL enc_valid it=%0d got=%b exp=%b", it, enc_resp_valid, pe_v);
         end else if (pe_v) begin
            find(pe_val, h, kk);
            total++;
            if (enc_resp_hit !== h || (h && enc_resp_key !== kk)) begin
               bad++; $display("FAIL enc_resp val=%0d got h=%b key=%0d exp h=%b key=%0d",
                               pe_val, enc_resp_hit, enc_resp_key, h, kk);
            end
         end
         total++;
         if (dec_resp_valid !== pd_v) begin
            bad++; $display("FAIL dec_valid it=%0d got=%b exp=%b", it, dec_resp_valid, pd_v);
         end else if (pd_v) begin
            total++;
            if (dec_resp_val !== dict_exp[pd_key]) begin
               bad++; $display("FAIL dec_resp key=%0d got=%0d exp=%0d", pd_key, dec_resp_val, dict_exp[pd_key]);
            end
         end
         total++;
         if (enc_req_ready !== 1'b1 || dec_req_ready !== 1'b1) begin
            bad++; $display("FAIL lookup_ready it=%0d got=%b%b exp=11", it, enc_req_ready, dec_req_ready);
         end
         if (it == n) begin
            enc_req_valid = 1'b0; dec_req_valid = 1'b0;
         end else if (directed && it == 0) begin
            enc_req_valid = 1'b1; enc_req_val = VW'(105);
            dec_req_valid = 1'b1; dec_req_key = KW'(127);
         end else if (directed && it == 1) begin
            enc_req_valid = 1'b1; enc_req_val = VW'(4000);
            dec_req_valid = 1'b0;
         end else begin
            enc_req_valid = ($urandom_range(0, 3) != 0);
            enc_req_val   = ($urandom_range(0, 1) != 0) ? dict_exp[$urandom_range(0, N - 1)] : VW'($urandom);
            dec_req_valid = ($urandom_range(0, 3) != 0);
            dec_req_key   = KW'($urandom);
         end
         pe_v = enc_req_valid; pe_val = enc_req_val;
         pd_v = dec_req_valid; pd_key = dec_req_key;
         tick();
      end
   endtask

   task automatic test_reset_mid_load();
      set_rom(0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      repeat (40) tick();
      total++;
      if (dict_we !== 1'b1) begin
         bad++; $display("FAIL mid_we_pre got=%b exp=1", dict_we);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({dict_we, rom_rd_en, load_busy, load_done} !== 4'b0) begin
         bad++; $display("FAIL mid_reset got=%b exp=0000", {dict_we, rom_rd_en, load_busy, load_done});
      end
      #3 reset = 1'b0;
      loaded = 1'b0;
      tick();
      total++;
      if ({load_done, enc_req_ready, dict_we} !== 3'b0) begin
         bad++; $display("FAIL post_reset got=%b exp=000", {load_done, enc_req_ready, dict_we});
      end
      run_load(1'b0, 1'b0, 1'b0);
      test_lookup(40, 1'b1);
   endtask

`ifdef DICT_LOAD_CHECKSUM_EN
   task automatic test_checksum();
      set_rom(2);
      run_load(1'b1, 1'b0, 1'b1);
      enc_req_valid = 1'b1; enc_req_val = rom[3];
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (load_err !== 1'b1 || enc_req_ready !== 1'b0 || enc_resp_valid !== 1'b0) begin
            bad++; $display("FAIL csum_bad k=%0d got err=%b rdy=%b resp=%b exp 1 0 0",
                            k, load_err, enc_req_ready, enc_resp_valid);
         end
      end
      enc_req_valid = 1'b0;
      tick();
      run_load(1'b0, 1'b0, 1'b0);
      test_lookup(20, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_idle_lookup();
      set_rom(0);
      run_load(1'b0, 1'b1, 1'b0);
      test_lookup(60, 1'b1);
      test_reset_mid_load();
      set_rom(1);
      run_load(1'b1, 1'b0, 1'b0);
      test_lookup(40, 1'b0);
      set_rom(2);
      run_load(1'b1, 1'b0, 1'b0);
      test_lookup(60, 1'b0);
`ifdef DICT_LOAD_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
